// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE, LOCK_C, LOCK_D)
//   PORT_C/D    : port identifiers, also used as bit index into 2-bit grant vectors
// Optional feature macro: DMEM_ARB_RR_EN (consumed by dmem_arb_pick).
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_C = 2'd1,
        LOCK_D = 2'd2
    } arb_state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational 2-way grant selector.
//   req_i[1:0]   in  requests, bit PORT_C / bit PORT_D
//   last_i       in  port of the most recent grant
//   force_i[1:0] in  ports allowed to win this cycle (lock / forced-release mask)
//   gnt_o[1:0]   out one-hot grant (or zero)
// Macro DMEM_ARB_RR_EN: defined -> round-robin on contention (port != last wins);
//                       undefined -> fixed priority, port C wins.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic [1:0] force_i,
    output logic [1:0] gnt_o
);

    logic [1:0] eligible;

`ifndef DMEM_ARB_RR_EN
    // Fixed priority never looks at the history bit.
    logic unused_last;
    assign unused_last = last_i;
`endif

    always_comb begin
        eligible = req_i & force_i;
        gnt_o    = 2'b00;
        case (eligible)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
`ifdef DMEM_ARB_RR_EN
                gnt_o = (last_i == PORT_D) ? 2'b01 : 2'b10;
`else
                gnt_o = 2'b01;
`endif
            end
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core (C) and a
// DMA/debug loader (D), with a bounded bus lock for atomic read-modify-write.
//   clk, rst                 clock, synchronous active-high reset
//   c_*/d_* req,we,addr,wdata,lock   requester inputs
//   c_gnt/d_gnt              combinational grant
//   c_rvalid/d_rvalid, c_rdata/d_rdata   registered read response (1-cycle latency)
//   mem_a, mem_we, mem_wd    to memory; mem_rd combinational read data from memory
// Macro DMEM_ARB_RR_EN selects round-robin contention (see dmem_arb_pick).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    input  logic          c_lock,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_lock,
    output logic          c_gnt,
    output logic          d_gnt,
    output logic          c_rvalid,
    output logic          d_rvalid,
    output logic [DW-1:0] c_rdata,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    arb_state_t    state_q;
    logic          last_q;
    logic          force_pend_q;   // set by a forced release until the next grant
    logic [CW-1:0] cnt_q;

    logic [1:0]    req;
    logic [1:0]    mask;
    logic [1:0]    pick_gnt;
    logic [1:0]    gnt;
    logic          any_gnt;
    logic          win_we;
    logic          win_lock;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          in_range;
    logic          owner;
    logic          lock_expired;

    assign req = {d_req, c_req};

    // Restrict who may win: lock owner only, or the non-last port right after a forced release.
    always_comb begin
        mask = 2'b11;
        case (state_q)
            LOCK_C:  mask = 2'b01;
            LOCK_D:  mask = 2'b10;
            default: begin
                if (force_pend_q && c_req && d_req) begin
                    mask = (last_q == PORT_C) ? 2'b10 : 2'b01;
                end
            end
        endcase
    end

    dmem_arb_pick u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .force_i (mask),
        .gnt_o   (pick_gnt)
    );

    assign gnt     = rst ? 2'b00 : pick_gnt;
    assign any_gnt = |gnt;
    assign c_gnt   = gnt[PORT_C];
    assign d_gnt   = gnt[PORT_D];

    // Winner mux; everything is zero when nobody is granted.
    always_comb begin
        win_we    = 1'b0;
        win_lock  = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (gnt[PORT_C]) begin
            win_we    = c_we;
            win_lock  = c_lock;
            win_addr  = c_addr;
            win_wdata = c_wdata;
        end else if (gnt[PORT_D]) begin
            win_we    = d_we;
            win_lock  = d_lock;
            win_addr  = d_addr;
            win_wdata = d_wdata;
        end
    end

    assign in_range = 64'(win_addr) < 64'(DEPTH);
    assign mem_a    = win_addr;
    assign mem_wd   = win_wdata;
    assign mem_we   = win_we & in_range;

    assign owner        = (state_q == LOCK_D) ? PORT_D : PORT_C;
    assign lock_expired = (cnt_q == CW'(LOCK_MAX - 1));

    // FSM, lock counter, grant history and read response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= PORT_D;
            force_pend_q <= 1'b0;
            cnt_q        <= '0;
            c_rvalid     <= 1'b0;
            d_rvalid     <= 1'b0;
            c_rdata      <= '0;
            d_rdata      <= '0;
        end else begin
            c_rvalid <= gnt[PORT_C] & ~c_we;
            d_rvalid <= gnt[PORT_D] & ~d_we;
            if (gnt[PORT_C] && !c_we) begin
                c_rdata <= in_range ? mem_rd : '0;
            end
            if (gnt[PORT_D] && !d_we) begin
                d_rdata <= in_range ? mem_rd : '0;
            end

            if (any_gnt) begin
                last_q       <= gnt[PORT_D] ? PORT_D : PORT_C;
                force_pend_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (any_gnt && win_lock) begin
                        state_q <= gnt[PORT_C] ? LOCK_C : LOCK_D;
                    end
                end
                LOCK_C, LOCK_D: begin
                    if (lock_expired) begin
                        // Forced release overrides whatever the owner did this cycle.
                        state_q      <= IDLE;
                        last_q       <= owner;
                        force_pend_q <= 1'b1;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (any_gnt && !win_lock) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
